// File: rtl/hash_table_lp.sv
// hash_table_lp: open-addressing key/value table with linear probing,
// tombstone deletion, in-place update and an elaboration-time hash choice.
// One operation at a time; each slot is examined in its own PROBE cycle.
module hash_table_lp #(
    parameter int    KEY_WIDTH      = 32,
    parameter int    VALUE_WIDTH    = 32,
    parameter int    DEPTH          = 16,
    parameter int    MAX_PROBE      = DEPTH,
    parameter string HASH_ALGORITHM = "MODULUS",
    localparam int   INDEX_WIDTH    = $clog2(DEPTH),
    localparam int   PCW            = $clog2(MAX_PROBE + 1),
    localparam int   ECW            = $clog2(DEPTH + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_op_en,
    input  logic [1:0]             i_op_sel,
    input  logic [KEY_WIDTH-1:0]   i_key_in,
    input  logic [VALUE_WIDTH-1:0] i_value_in,
    output logic                   o_op_ready,
    output logic                   o_op_done,
    output logic [1:0]             o_op_status,
    output logic [VALUE_WIDTH-1:0] o_value_out,
    output logic [PCW-1:0]         o_probe_count,
    output logic [ECW-1:0]         o_entry_count,
    output logic                   o_full
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_HASH  = 2'b01,
        ST_PROBE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'b00,
        SLOT_VALID = 2'b01,
        SLOT_TOMB  = 2'b10
    } slot_t;

    localparam logic [1:0] OP_INSERT = 2'b00;
    localparam logic [1:0] OP_DELETE = 2'b01;
    localparam logic [1:0] OP_SEARCH = 2'b10;
    localparam logic [1:0] OP_CLEAR  = 2'b11;

    localparam logic [1:0] STATUS_OK        = 2'b00;
    localparam logic [1:0] STATUS_NOT_FOUND = 2'b01;
    localparam logic [1:0] STATUS_FULL      = 2'b10;

    // FNV-1a over the key bytes, least significant byte first, folded to a slot index.
    function automatic logic [INDEX_WIDTH-1:0] fnv1aIndex(input logic [KEY_WIDTH-1:0] key);
        logic [31:0] h;
        h = 32'h811C9DC5;
        for (int b = 0; b < KEY_WIDTH / 8; b++) begin
            h = (h ^ {24'd0, key[b*8 +: 8]}) * 32'h01000193;
        end
        return h[INDEX_WIDTH-1:0];
    endfunction

    state_t                 r_state;
    state_t                 w_stateNext;

    logic [1:0]             r_op;
    logic [KEY_WIDTH-1:0]   r_key;
    logic [VALUE_WIDTH-1:0] r_value;
    logic [INDEX_WIDTH-1:0] r_idx;
    logic [PCW-1:0]         r_probes;
    logic                   r_freeFound;
    logic [INDEX_WIDTH-1:0] r_freeIdx;

    slot_t                  r_slotState [DEPTH];
    logic [KEY_WIDTH-1:0]   r_slotKey   [DEPTH];
    logic [VALUE_WIDTH-1:0] r_slotValue [DEPTH];

    logic [1:0]             r_status;
    logic [VALUE_WIDTH-1:0] r_valueOut;
    logic [PCW-1:0]         r_probeCount;
    logic [ECW-1:0]         r_entryCount;

    logic [INDEX_WIDTH-1:0] w_hashIdx;
    slot_t                  w_curState;
    logic                   w_hit;
    logic                   w_curFree;
    logic [PCW-1:0]         w_examined;
    logic                   w_probeEnd;
    logic                   w_freeAvail;
    logic [INDEX_WIDTH-1:0] w_freeIdx;
    logic                   w_termEdge;

    // Home slot: either the low key bits or the folded FNV-1a hash.
    generate
        if (HASH_ALGORITHM == "FNV1A") begin : g_hashFnv
            assign w_hashIdx = fnv1aIndex(r_key);
        end else begin : g_hashMod
            assign w_hashIdx = r_key[INDEX_WIDTH-1:0];
        end
    endgenerate

    // Evaluate the slot under the probe pointer and decide whether probing ends here.
    always_comb begin
        w_curState  = r_slotState[r_idx];
        w_hit       = (w_curState == SLOT_VALID) && (r_slotKey[r_idx] == r_key);
        w_curFree   = (w_curState != SLOT_VALID);
        w_examined  = r_probes + PCW'(1);
        w_probeEnd  = w_hit || (w_curState == SLOT_EMPTY) || (w_examined == PCW'(MAX_PROBE));
        w_freeAvail = r_freeFound || w_curFree;
        w_freeIdx   = r_freeFound ? r_freeIdx : r_idx;
        w_termEdge  = (r_state == ST_PROBE) && w_probeEnd;
    end

    // State register for the operation sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and handshake outputs; clear skips hashing and probing entirely.
    always_comb begin
        w_stateNext = r_state;
        o_op_ready  = 1'b0;
        o_op_done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                o_op_ready = 1'b1;
                if (i_op_en) begin
                    w_stateNext = (i_op_sel == OP_CLEAR) ? ST_DONE : ST_HASH;
                end
            end
            ST_HASH: begin
                w_stateNext = ST_PROBE;
            end
            ST_PROBE: begin
                if (w_probeEnd) begin
                    w_stateNext = ST_DONE;
                end
            end
            ST_DONE: begin
                o_op_done   = 1'b1;
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Operation latch, probe walk, slot states, counters and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op         <= OP_INSERT;
            r_key        <= '0;
            r_value      <= '0;
            r_idx        <= '0;
            r_probes     <= '0;
            r_freeFound  <= 1'b0;
            r_freeIdx    <= '0;
            r_status     <= STATUS_OK;
            r_valueOut   <= '0;
            r_probeCount <= '0;
            r_entryCount <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slotState[i] <= SLOT_EMPTY;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_op_en) begin
                        r_op    <= i_op_sel;
                        r_key   <= i_key_in;
                        r_value <= i_value_in;
                        if (i_op_sel == OP_CLEAR) begin
                            for (int i = 0; i < DEPTH; i++) begin
                                r_slotState[i] <= SLOT_EMPTY;
                            end
                            r_entryCount <= '0;
                            r_probeCount <= '0;
                            r_status     <= STATUS_OK;
                            r_valueOut   <= '0;
                        end
                    end
                end
                ST_HASH: begin
                    r_idx       <= w_hashIdx;
                    r_probes    <= '0;
                    r_freeFound <= 1'b0;
                    r_freeIdx   <= '0;
                end
                ST_PROBE: begin
                    if (!w_probeEnd) begin
                        r_idx    <= r_idx + INDEX_WIDTH'(1);
                        r_probes <= w_examined;
                        if (!r_freeFound && w_curFree) begin
                            r_freeFound <= 1'b1;
                            r_freeIdx   <= r_idx;
                        end
                    end else begin
                        r_probeCount <= w_examined;
                        r_valueOut   <= '0;
                        case (r_op)
                            OP_INSERT: begin
                                if (w_hit) begin
                                    r_status <= STATUS_OK;
                                end else if (w_freeAvail) begin
                                    r_slotState[w_freeIdx] <= SLOT_VALID;
                                    r_entryCount           <= r_entryCount + ECW'(1);
                                    r_status               <= STATUS_OK;
                                end else begin
                                    r_status <= STATUS_FULL;
                                end
                            end
                            OP_DELETE: begin
                                if (w_hit) begin
                                    r_slotState[r_idx] <= SLOT_TOMB;
                                    r_entryCount       <= r_entryCount - ECW'(1);
                                    r_status           <= STATUS_OK;
                                end else begin
                                    r_status <= STATUS_NOT_FOUND;
                                end
                            end
                            OP_SEARCH: begin
                                if (w_hit) begin
                                    r_valueOut <= r_slotValue[r_idx];
                                    r_status   <= STATUS_OK;
                                end else begin
                                    r_status <= STATUS_NOT_FOUND;
                                end
                            end
                            default: begin
                                r_status <= STATUS_OK;
                            end
                        endcase
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Key/value storage; no reset needed because slot state alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_termEdge && (r_op == OP_INSERT)) begin
            if (w_hit) begin
                r_slotValue[r_idx] <= r_value;
            end else if (w_freeAvail) begin
                r_slotKey[w_freeIdx]   <= r_key;
                r_slotValue[w_freeIdx] <= r_value;
            end
        end
    end

    assign o_op_status   = r_status;
    assign o_value_out   = r_valueOut;
    assign o_probe_count = r_probeCount;
    assign o_entry_count = r_entryCount;
    assign o_full        = (r_entryCount == ECW'(DEPTH));

endmodule

// File: tb/tb_hash_table_lp.sv
// tb_hash_table_lp: directed table of the documented scenarios, hand-written
// handshake/reset sequences, then random operations against a reference model.
module tb_hash_table_lp;

    localparam int DEPTH = 8;
    localparam int MAXP  = 8;
    localparam int PCW   = $clog2(MAXP + 1);
    localparam int ECW   = $clog2(DEPTH + 1);

    localparam logic [1:0] OP_INS = 2'b00;
    localparam logic [1:0] OP_DEL = 2'b01;
    localparam logic [1:0] OP_SRC = 2'b10;
    localparam logic [1:0] OP_CLR = 2'b11;

    localparam logic [1:0] S_OK   = 2'b00;
    localparam logic [1:0] S_NF   = 2'b01;
    localparam logic [1:0] S_FULL = 2'b10;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] key;
        logic [31:0] val;
        logic [1:0]  expStatus;
        logic [31:0] expValue;
        int          expProbes;
        int          expCount;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_op_en = 1'b0;
    logic [1:0]       i_op_sel = 2'b00;
    logic [31:0]      i_key_in = '0;
    logic [31:0]      i_value_in = '0;
    logic             o_op_ready;
    logic             o_op_done;
    logic [1:0]       o_op_status;
    logic [31:0]      o_value_out;
    logic [PCW-1:0]   o_probe_count;
    logic [ECW-1:0]   o_entry_count;
    logic             o_full;

    int testsRun  = 0;
    int failCount = 0;

    // Reference model: slot contents as plain arrays (0 empty, 1 valid, 2 tombstone).
    int          mState [DEPTH];
    logic [31:0] mKey   [DEPTH];
    logic [31:0] mVal   [DEPTH];
    int          mCount;

    vec_t vecs[$];

    hash_table_lp #(
        .KEY_WIDTH(32),
        .VALUE_WIDTH(32),
        .DEPTH(DEPTH),
        .MAX_PROBE(MAXP),
        .HASH_ALGORITHM("MODULUS")
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .i_op_en(i_op_en),
        .i_op_sel(i_op_sel),
        .i_key_in(i_key_in),
        .i_value_in(i_value_in),
        .o_op_ready(o_op_ready),
        .o_op_done(o_op_done),
        .o_op_status(o_op_status),
        .o_value_out(o_value_out),
        .o_probe_count(o_probe_count),
        .o_entry_count(o_entry_count),
        .o_full(o_full)
    );

    // 100 MHz free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        testsRun++;
        failCount++;
        $display("[TB] FAIL %s: no completion within cycle budget", name);
    endtask

    task automatic modelReset();
        for (int i = 0; i < DEPTH; i++) begin
            mState[i] = 0;
            mKey[i]   = '0;
            mVal[i]   = '0;
        end
        mCount = 0;
    endtask

    // Apply one operation to the model; probing follows the documented stop rules.
    task automatic modelOp(input logic [1:0] op, input logic [31:0] key, input logic [31:0] val,
                           output logic [1:0] st, output logic [31:0] value, output int probes);
        int home;
        int slot;
        int freeSlot;
        int hitSlot;
        st = S_OK;
        value = '0;
        probes = 0;
        if (op == OP_CLR) begin
            modelReset();
            return;
        end
        home = int'(key % DEPTH);
        freeSlot = -1;
        hitSlot = -1;
        for (int n = 0; n < MAXP; n++) begin
            slot = (home + n) % DEPTH;
            probes = n + 1;
            if (mState[slot] == 1 && mKey[slot] == key) begin
                hitSlot = slot;
                break;
            end
            if (mState[slot] != 1 && freeSlot < 0) freeSlot = slot;
            if (mState[slot] == 0) break;
        end
        case (op)
            OP_INS: begin
                if (hitSlot >= 0) begin
                    mVal[hitSlot] = val;
                end else if (freeSlot >= 0) begin
                    mState[freeSlot] = 1;
                    mKey[freeSlot] = key;
                    mVal[freeSlot] = val;
                    mCount++;
                end else begin
                    st = S_FULL;
                end
            end
            OP_DEL: begin
                if (hitSlot >= 0) begin
                    mState[hitSlot] = 2;
                    mCount--;
                end else begin
                    st = S_NF;
                end
            end
            default: begin
                if (hitSlot >= 0) value = mVal[hitSlot];
                else st = S_NF;
            end
        endcase
    endtask

    // Drive one request when the block is ready and wait (bounded) for op_done.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] key, input logic [31:0] val,
                                 input bit glitch, output int latency, output bit timedOut,
                                 output logic [1:0] st, output logic [31:0] value, output int probes,
                                 output int count, output bit fullFlag);
        int guard;
        latency = 0;
        timedOut = 1'b0;
        st = '0;
        value = '0;
        probes = 0;
        count = 0;
        fullFlag = 1'b0;
        guard = 0;
        while (!o_op_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!o_op_ready) begin
            timedOut = 1'b1;
            return;
        end
        i_op_en = 1'b1;
        i_op_sel = op;
        i_key_in = key;
        i_value_in = val;
        @(posedge clk);
        #1;
        i_op_en = 1'b0;
        i_op_sel = 2'($urandom);
        i_key_in = $urandom;
        i_value_in = $urandom;
        while (latency < 40) begin
            @(negedge clk);
            latency++;
            if (o_op_done) break;
            if (glitch && latency == 2) begin
                i_op_en = 1'b1;
                i_op_sel = OP_CLR;
            end
            if (glitch && latency == 3) i_op_en = 1'b0;
        end
        if (!o_op_done) begin
            timedOut = 1'b1;
            return;
        end
        st = o_op_status;
        value = o_value_out;
        probes = int'(o_probe_count);
        count = int'(o_entry_count);
        fullFlag = o_full;
    endtask

    task automatic runAndCheck(input string name, input logic [1:0] op, input logic [31:0] key,
                               input logic [31:0] val, input logic [1:0] expStatus,
                               input logic [31:0] expValue, input int expProbes, input int expCount,
                               input bit glitch);
        int latency;
        bit timedOut;
        logic [1:0] st;
        logic [31:0] value;
        int probes;
        int count;
        bit fullFlag;
        applyStimulus(op, key, val, glitch, latency, timedOut, st, value, probes, count, fullFlag);
        if (timedOut) begin
            reportTimeout(name);
            return;
        end
        checkOutput({name, " status"}, 32'(st), 32'(expStatus));
        checkOutput({name, " value"}, value, expValue);
        checkOutput({name, " probes"}, 32'(probes), 32'(expProbes));
        checkOutput({name, " count"}, 32'(count), 32'(expCount));
        checkOutput({name, " full"}, 32'(fullFlag), 32'(expCount == DEPTH));
        checkOutput({name, " latency"}, 32'(latency), (op == OP_CLR) ? 32'd1 : 32'(2 + expProbes));
        @(negedge clk);
        checkOutput({name, " done/ready after"}, {30'd0, o_op_done, o_op_ready}, 32'd1);
    endtask

    // Run an operation whose expectations come from the reference model.
    task automatic modelRun(input string name, input logic [1:0] op, input logic [31:0] key,
                            input logic [31:0] val, input bit glitch);
        logic [1:0] st;
        logic [31:0] value;
        int probes;
        modelOp(op, key, val, st, value, probes);
        runAndCheck(name, op, key, val, st, value, probes, mCount, glitch);
    endtask

    // Main test sequence.
    initial begin
        logic [1:0] st;
        logic [31:0] value;
        int probes;
        bit sawDone;
        int r;

        modelReset();
        vecs.push_back(vec_t'{OP_INS, 32'h03, 32'hAA, S_OK,   32'h00, 1, 1});
        vecs.push_back(vec_t'{OP_INS, 32'h0B, 32'hBB, S_OK,   32'h00, 2, 2});
        vecs.push_back(vec_t'{OP_SRC, 32'h0B, 32'h00, S_OK,   32'hBB, 2, 2});
        vecs.push_back(vec_t'{OP_SRC, 32'h13, 32'h00, S_NF,   32'h00, 3, 2});
        vecs.push_back(vec_t'{OP_DEL, 32'h03, 32'h00, S_OK,   32'h00, 1, 1});
        vecs.push_back(vec_t'{OP_SRC, 32'h0B, 32'h00, S_OK,   32'hBB, 2, 1});
        vecs.push_back(vec_t'{OP_INS, 32'h13, 32'hCC, S_OK,   32'h00, 3, 2});
        vecs.push_back(vec_t'{OP_INS, 32'h07, 32'h01, S_OK,   32'h00, 1, 3});
        vecs.push_back(vec_t'{OP_INS, 32'h0F, 32'h02, S_OK,   32'h00, 2, 4});
        vecs.push_back(vec_t'{OP_INS, 32'h0F, 32'h05, S_OK,   32'h00, 2, 4});
        vecs.push_back(vec_t'{OP_SRC, 32'h0F, 32'h00, S_OK,   32'h05, 2, 4});
        vecs.push_back(vec_t'{OP_SRC, 32'h13, 32'h00, S_OK,   32'hCC, 1, 4});
        vecs.push_back(vec_t'{OP_INS, 32'h01, 32'h11, S_OK,   32'h00, 1, 5});
        vecs.push_back(vec_t'{OP_INS, 32'h02, 32'h22, S_OK,   32'h00, 1, 6});
        vecs.push_back(vec_t'{OP_INS, 32'h05, 32'h55, S_OK,   32'h00, 1, 7});
        vecs.push_back(vec_t'{OP_INS, 32'h06, 32'h66, S_OK,   32'h00, 1, 8});
        vecs.push_back(vec_t'{OP_INS, 32'h21, 32'h99, S_FULL, 32'h00, 8, 8});
        vecs.push_back(vec_t'{OP_DEL, 32'h99, 32'h00, S_NF,   32'h00, 8, 8});
        vecs.push_back(vec_t'{OP_SRC, 32'h06, 32'h00, S_OK,   32'h66, 1, 8});
        vecs.push_back(vec_t'{OP_CLR, 32'h00, 32'h00, S_OK,   32'h00, 0, 0});
        vecs.push_back(vec_t'{OP_SRC, 32'h0B, 32'h00, S_NF,   32'h00, 1, 0});

        // Reset and check reset values.
        repeat (3) @(negedge clk);
        checkOutput("reset ready", 32'(o_op_ready), 32'd1);
        checkOutput("reset done", 32'(o_op_done), 32'd0);
        checkOutput("reset status", 32'(o_op_status), 32'd0);
        checkOutput("reset value", o_value_out, 32'd0);
        checkOutput("reset probes", 32'(o_probe_count), 32'd0);
        checkOutput("reset count", 32'(o_entry_count), 32'd0);
        checkOutput("reset full", 32'(o_full), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table of the documented scenarios.
        foreach (vecs[i]) begin
            modelOp(vecs[i].op, vecs[i].key, vecs[i].val, st, value, probes);
            runAndCheck($sformatf("vec%0d", i), vecs[i].op, vecs[i].key, vecs[i].val,
                        vecs[i].expStatus, vecs[i].expValue, vecs[i].expProbes, vecs[i].expCount, 1'b0);
        end

        // op_en pulsed (as a clear) during PROBE must be dropped.
        modelRun("pre 08", OP_INS, 32'h08, 32'h80, 1'b0);
        modelRun("pre 10", OP_INS, 32'h10, 32'h81, 1'b0);
        runAndCheck("glitch 18", OP_INS, 32'h18, 32'h82, S_OK, 32'h0, 3, 3, 1'b1);
        modelOp(OP_INS, 32'h18, 32'h82, st, value, probes);
        sawDone = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (o_op_done) sawDone = 1'b1;
        end
        checkOutput("glitch no extra done", 32'(sawDone), 32'd0);
        checkOutput("glitch count kept", 32'(o_entry_count), 32'd3);

        // Reset asserted during PROBE aborts the insert of 0x20 (would take 4 probes).
        i_op_en = 1'b1;
        i_op_sel = OP_INS;
        i_key_in = 32'h20;
        i_value_in = 32'h1234;
        @(posedge clk);
        #1;
        i_op_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("abort ready", 32'(o_op_ready), 32'd1);
        checkOutput("abort done", 32'(o_op_done), 32'd0);
        checkOutput("abort probes", 32'(o_probe_count), 32'd0);
        checkOutput("abort count", 32'(o_entry_count), 32'd0);
        checkOutput("abort value", o_value_out, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        sawDone = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (o_op_done) sawDone = 1'b1;
        end
        checkOutput("abort no done", 32'(sawDone), 32'd0);
        modelReset();
        modelRun("post abort 20", OP_SRC, 32'h20, 32'h0, 1'b0);
        modelRun("post abort 08", OP_SRC, 32'h08, 32'h0, 1'b0);

        // Randomised operations on a small key range to force collisions and full tables.
        for (int n = 0; n < 200; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45)      modelRun($sformatf("rnd%0d ins", n), OP_INS, 32'($urandom_range(0, 23)), $urandom, 1'b0);
            else if (r < 60) modelRun($sformatf("rnd%0d del", n), OP_DEL, 32'($urandom_range(0, 23)), $urandom, 1'b0);
            else if (r < 96) modelRun($sformatf("rnd%0d src", n), OP_SRC, 32'($urandom_range(0, 23)), $urandom, 1'b0);
            else             modelRun($sformatf("rnd%0d clr", n), OP_CLR, $urandom, $urandom, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/hash_table_lp.md
# hash_table_lp

Open-addressing hash table with linear probing, tombstone deletion, in-place update and selectable hash function. Successor to the chaining hash table: each stored key occupies exactly one slot, and the hash algorithm is selected at elaboration time. Operations are accepted one at a time through a ready/enable handshake, with a one-cycle completion pulse. The block sits beside the other data-structure blocks as a key/value lookup engine.

## Interface
- KEY_WIDTH, 32: key width in bits; must be a multiple of 8 when FNV1A is selected.
- VALUE_WIDTH, 32: value width in bits.
- DEPTH, 16: number of slots; power of 2, at least 2. INDEX_WIDTH = $clog2(DEPTH).
- MAX_PROBE, DEPTH: maximum slots examined per operation, 1..DEPTH.
- HASH_ALGORITHM, "MODULUS": either "MODULUS" or "FNV1A".
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- op_en  in  1  operation request; sampled only while op_ready=1.
- op_sel  in  2  operation code: 00 insert/update, 01 delete, 10 search, 11 clear-all.
- key_in  in  KEY_WIDTH  operation key.
- value_in  in  VALUE_WIDTH  insert value.
- op_ready  out  1  block idle; a request may be accepted.
- op_done  out  1  one-cycle completion pulse.
- op_status  out  2  valid with op_done: 00 OK, 01 NOT_FOUND, 10 FULL, 11 reserved.
- value_out  out  VALUE_WIDTH  search result.
- probe_count  out  $clog2(MAX_PROBE+1)  number of slots examined by the last operation.
- entry_count  out  $clog2(DEPTH+1)  number of VALID slots.
- full  out  1  entry_count == DEPTH.

## Operation
- Slot state is 2 bits: EMPTY, VALID or TOMB. Slots hold key and value arrays.
- Accept: op_en & op_ready latches op_sel, key_in and value_in. Later input changes are ignored. op_en while op_ready=0 is dropped.
- Hash:
  - MODULUS: idx = key[INDEX_WIDTH-1:0].
  - FNV1A: 32-bit FNV-1a over key bytes, LSB byte first. Offset basis 32'h811C9DC5, prime 32'h01000193. idx = h[INDEX_WIDTH-1:0].
- Probing: starts at idx. Each probe increments idx mod DEPTH, wrapping DEPTH-1→0.
  - A probe stops on: VALID slot with a matching key (hit); an EMPTY slot; or MAX_PROBE slots examined.
  - TOMB slots never stop a probe.
- Insert:
  - On a hit, the value is overwritten; status OK; entry_count unchanged.
  - On a miss, the key/value are written to the first TOMB or EMPTY slot seen during the probe; the slot becomes VALID; entry_count+1; status OK.
  - If no free slot was seen, status is FULL and nothing is written.
  - The insert keeps probing past a TOMB until it hits or meets EMPTY, so duplicate keys can never be created.
- Delete: on a hit, the slot becomes TOMB, entry_count-1, status OK. On a miss, status NOT_FOUND.
- Search: on a hit, value_out = stored value, status OK. On a miss, value_out = 0, status NOT_FOUND.
- Clear: all slots become EMPTY in one cycle; entry_count=0; probe_count=0; status OK.
- value_out, probe_count and op_status update only at completion and hold until the next completion.
- Insert and delete leave value_out at 0.

## Timing
- States:
  - IDLE (op_ready=1).
  - HASH: compute idx, register it.
  - PROBE: one slot examined per cycle.
  - DONE: op_done=1 for one cycle.
  - Transitions: IDLE→HASH on accept; HASH→PROBE; PROBE→PROBE while continuing; PROBE→DONE on termination; DONE→IDLE. Clear goes IDLE→DONE directly.
- Array write and counter updates take effect on the clock edge leaving the terminal PROBE cycle. Status outputs become visible during DONE.
- Latency, accept at edge T:
  - HASH in cycle T+1.
  - The k-th probe occurs in cycle T+1+k.
  - op_done is high in cycle T+2+k.
  - op_ready returns in cycle T+3+k.
  - Clear: op_done at T+1.
- Worst-case latency is MAX_PROBE+2 cycles to op_done.
- Reset values: op_ready=1; op_done=0; op_status=0; value_out=0; probe_count=0; entry_count=0; full=0; every slot EMPTY; state IDLE.
- Reset asserted mid-operation aborts the operation immediately. No partial write survives, and no op_done is issued.
- Counters never wrap: insert to a full table returns FULL; delete of an absent key returns NOT_FOUND.

## Test plan
Bench configuration: DEPTH=8, MODULUS, MAX_PROBE=8, KEY/VALUE 32.
- Insert and collision:
  - Reset, then insert (0x03, 0xAA) → OK, probe_count=1, entry_count=1, op_done exactly 3 cycles after accept.
  - Insert (0x0B, 0xBB) → stored in slot 4, probe_count=2.
- Search hit and miss:
  - Search 0x0B → value_out=0xBB, OK, probe_count=2.
  - Search 0x13 → NOT_FOUND, value_out=0, probe_count=3.
- Tombstone handling:
  - Delete 0x03 → OK, entry_count=1.
  - Search 0x0B → still found, probe_count=2.
  - Insert (0x13, 0xCC) → reuses slot 3, probe_count=3, entry_count=2.
- Update and wrap:
  - Insert (0x07, 1), then (0x0F, 2) → the second lands in slot 0.
  - Insert (0x0F, 5) → overwrite; entry_count unchanged; search 0x0F returns 5.
- Full table:
  - Fill 8 distinct keys → full=1.
  - A 9th insert → FULL, probe_count=8.
  - Delete of an absent key → NOT_FOUND.
- Clear, reset and handshake:
  - Clear → op_done 1 cycle after accept; entry_count=0; every search misses.
  - Pulse op_en during PROBE → ignored.
  - Assert rst_n low during PROBE → outputs take reset values; no op_done.
